rx_bit_timer: RTL and testbench

Bit-period timing stage for the receive path: tracks the phase within each serial bit period, resynchronises on line transitions, and emits one sample/shift strobe per bit plus a byte-complete pulse every `BITS_PER_BYTE` bits. It sits between the edge detector (source of `d_edge`) and the shift register / RX controller (consumers of `shift_strobe` and `byte_done`). Internally it drives the team's flexible counter as its bit counter.

---
 rtl/rx_timer_pkg.sv | 13 +
 rtl/rx_bit_timer_flex_counter.sv | 49 ++++
 rtl/rx_bit_timer.sv | 96 +++++++++
 tb/tb_rx_bit_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_timer_pkg.sv
// Shared types and default timing constants for the receive bit timer.
package rx_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_timer_state_t;

    localparam int RX_CLKS_PER_BIT  = 8;
    localparam int RX_SAMPLE_POINT  = 4;
    localparam int RX_BITS_PER_BYTE = 8;

endpackage

// File: rtl/rx_bit_timer_flex_counter.sv
// Flexible rollover counter: counts 0..rollover_val, then wraps to 1.
// Synchronous clear has priority over counting.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_reg;
    logic [NUM_CNT_BITS-1:0] count_next;
    logic                    flag_reg;
    logic                    flag_next;

    // Next count and flag: flag is high while the count sits at rollover_val.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            if (count_reg == rollover_val) begin
                count_next = NUM_CNT_BITS'(1);
            end else begin
                count_next = count_reg + NUM_CNT_BITS'(1);
            end
        end
        flag_next = (count_next == rollover_val);
    end

    // Count and flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            flag_reg  <= flag_next;
        end
    end

    assign count_out     = count_reg;
    assign rollover_flag = flag_reg;

endmodule

// File: rtl/rx_bit_timer.sv
// Bit-period timer for the receive path: phase tracking with resync on
// line edges, one shift strobe per bit and a byte-complete pulse.
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = RX_CLKS_PER_BIT,
    parameter int SAMPLE_POINT  = RX_SAMPLE_POINT,
    parameter int BITS_PER_BYTE = RX_BITS_PER_BYTE
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       d_edge,
    output logic       shift_strobe,
    output logic       byte_done,
    output logic [3:0] bit_cnt,
    output logic       busy
);

    localparam logic [3:0] CPB_V = 4'(CLKS_PER_BIT);
    localparam logic [3:0] SP_V  = 4'(SAMPLE_POINT);
    localparam logic [3:0] BPB_V = 4'(BITS_PER_BYTE);

    rx_timer_state_t state_reg;
    rx_timer_state_t state_next;
    logic [3:0]      phase_reg;
    logic [3:0]      phase_next;
    logic            full_prev_reg;
    logic            byte_full;
    logic            cnt_clear;

    // Next state and phase; dropping enable overrides any resync or wrap.
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        case (state_reg)
            IDLE: begin
                phase_next = 4'd0;
                if (enable) begin
                    state_next = RUN;
                    phase_next = 4'd1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                    phase_next = 4'd0;
                end else if (d_edge || (phase_reg == CPB_V)) begin
                    phase_next = 4'd1;
                end else begin
                    phase_next = phase_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = 4'd0;
            end
        endcase
    end

    // State, phase and byte-full history registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            phase_reg     <= 4'd0;
            full_prev_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            full_prev_reg <= byte_full;
        end
    end

    assign busy         = (state_reg == RUN);
    assign shift_strobe = busy && (phase_reg == SP_V);

    // Counter is held at zero in IDLE and on the cycle that leaves RUN.
    assign cnt_clear = (state_reg == IDLE) || !enable;

    flex_counter #(
        .NUM_CNT_BITS(4)
    ) u_bit_counter (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (shift_strobe),
        .rollover_val (BPB_V),
        .count_out    (bit_cnt),
        .rollover_flag()
    );

    // Pulse on the first cycle the counter shows a full byte.
    assign byte_full = (bit_cnt == BPB_V);
    assign byte_done = busy && byte_full && !full_prev_reg;

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer with a behavioural reference model.
module tb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 4;
    localparam int BPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       enable = 1'b0;
    logic       d_edge = 1'b0;
    logic       shift_strobe;
    logic       byte_done;
    logic [3:0] bit_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rx_bit_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP),
        .BITS_PER_BYTE(BPB)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable      (enable),
        .d_edge      (d_edge),
        .shift_strobe(shift_strobe),
        .byte_done   (byte_done),
        .bit_cnt     (bit_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, phase, strobes taken in this run.
    bit m_run;
    int m_phase;
    int m_nstrobe;
    bit m_prev_full;

    function automatic int exp_cnt();
        return (m_nstrobe == 0) ? 0 : ((m_nstrobe - 1) % BPB) + 1;
    endfunction

    function automatic int exp_strobe();
        return (m_run && m_phase == SP) ? 1 : 0;
    endfunction

    function automatic int exp_done();
        return (m_run && exp_cnt() == BPB && !m_prev_full) ? 1 : 0;
    endfunction

    // Model advance on each clock edge; cleared by the asynchronous reset.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_run       <= 1'b0;
            m_phase     <= 0;
            m_nstrobe   <= 0;
            m_prev_full <= 1'b0;
        end else begin
            m_prev_full <= (exp_cnt() == BPB);
            if (!m_run) begin
                if (enable) begin
                    m_run   <= 1'b1;
                    m_phase <= 1;
                end
            end else if (!enable) begin
                m_run     <= 1'b0;
                m_phase   <= 0;
                m_nstrobe <= 0;
            end else begin
                if (exp_strobe() != 0) m_nstrobe <= m_nstrobe + 1;
                if (d_edge || m_phase == CPB) m_phase <= 1;
                else m_phase <= m_phase + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (n_rst) begin
            chk("busy", 32'(busy), 32'(m_run));
            chk("shift_strobe", 32'(shift_strobe), 32'(exp_strobe()));
            chk("bit_cnt", 32'(bit_cnt), 32'(exp_cnt()));
            chk("byte_done", 32'(byte_done), 32'(exp_done()));
            if (byte_done) $display("byte_done at %0t bit_cnt=%0d", $time, bit_cnt);
        end
    end

    task automatic go_idle();
        enable = 1'b0;
        d_edge = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int npulse;
    int last_c;

    initial begin
        // Reset, then idle with d_edge toggling.
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cnt", 32'(bit_cnt), 0);
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            d_edge = c[0];
            @(negedge clk);
            chk("idle_outputs", 32'({busy, shift_strobe, byte_done, bit_cnt}), 0);
        end
        $display("idle phase done");

        // Steady byte with defaults.
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            chk("steady_strobe", 32'(shift_strobe), 32'((c % 8) == 4));
            chk("steady_done", 32'(byte_done), 32'(c == 61));
            if (c == 1)  chk("steady_busy1", 32'(busy), 1);
            if (c == 61) chk("steady_cnt61", 32'(bit_cnt), 8);
            if (c == 62) chk("steady_cnt62", 32'(bit_cnt), 8);
            if (c == 69) chk("steady_cnt69", 32'(bit_cnt), 1);
        end
        $display("steady byte done");

        // Resync before the sample point delays the strobe.
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 12) chk("resyncA_no12", 32'(shift_strobe), 0);
            if (c == 14) chk("resyncA_at14", 32'(shift_strobe), 1);
            if (c == 22) chk("resyncA_at22", 32'(shift_strobe), 1);
            d_edge = (c == 10);
        end
        $display("resync A done");

        // Edge coincident with the sample point keeps the strobe.
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 12) chk("resyncB_at12", 32'(shift_strobe), 1);
            if (c == 16) chk("resyncB_at16", 32'(shift_strobe), 1);
            d_edge = (c == 12);
        end
        $display("resync B done");

        // Abort after the fifth strobe, then re-enable.
        go_idle();
        enable = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(byte_done), 0);
            if (c == 37) chk("abort_cnt37", 32'(bit_cnt), 5);
            if (c == 38) chk("abort_idle38", 32'({busy, bit_cnt}), 0);
            if (c == 44) chk("abort_restrobe44", 32'(shift_strobe), 1);
            if (c == 45) chk("abort_cnt45", 32'(bit_cnt), 1);
            enable = !(c >= 37 && c < 40);
        end
        $display("abort done");

        // Three back-to-back bytes.
        go_idle();
        enable = 1'b1;
        npulse = 0;
        last_c = 0;
        for (int c = 1; c <= 195; c++) begin
            @(negedge clk);
            if (byte_done) begin
                npulse++;
                if (npulse == 1) chk("b2b_first", c, 61);
                else chk("b2b_spacing", c - last_c, 64);
                last_c = c;
            end
        end
        chk("b2b_pulses", npulse, 3);
        $display("back-to-back done");

        // Randomized enable drops and line edges.
        go_idle();
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 199) != 0);
            d_edge = ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end
        $display("random phase done");

        // Asynchronous reset at phase 3.
        go_idle();
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("areset_outputs", 32'({busy, shift_strobe, byte_done, bit_cnt}), 0);
        enable = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("areset_quiet", 32'({busy, shift_strobe, bit_cnt}), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
